mem_stage_reg: RTL
==================

Name: mem_stage_reg

Overview:
- Parametrised MEM pipeline stage for the five-stage MIPS core, sitting between the EX/MEM and MEM/WB boundaries.
- Holds a synchronous word-organised data memory and executes word, halfword and byte loads and stores, little-endian.
- Forwards store data from the W stage and registers all results into the MEM/WB pipeline register.
- Adds stall, flush and address-fault detection.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words in data memory.
- ADDR_BASE, 32'h0000_0000, byte address of word 0.
- PC_RESET, 32'h0000_3000, reset value of npc.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold the stage: no register update, no memory write.
- flush  in  1  load a bubble into the output register.
- pc  in  32  instruction PC.
- code  in  32  instruction word.
- alu_res  in  32  memory byte address for loads/stores; result value otherwise.
- st_data  in  32  rt value for stores, before forwarding.
- rg_waddr  in  5  destination register.
- rg_wtime  in  32  cycles until the result is ready.
- w_rg_waddr  in  5  W-stage destination, for forwarding.
- w_rg_wdata  in  32  W-stage write data.
- w_rg_wtime  in  32  W-stage time field.
- npc  out  32  registered pc.
- ncode  out  32  registered code.
- out_data  out  32  load data or pass-through alu_res.
- nrg_waddr  out  5  registered destination.
- nrg_wtime  out  32  registered time field.
- exc_code  out  2  0 none, 1 load address fault, 2 store address fault.

Behaviour:
- Clocking and reset: reset, synchronous, active-high; clock clk.
- Priority: reset > stall > flush > normal.
- Reset values: npc=PC_RESET; ncode, out_data, nrg_waddr, nrg_wtime and exc_code = 0; every memory word = 0. Reset takes effect on the same edge.
- Stall: all outputs hold; memory unchanged.
- Flush (no stall):
  - npc<=pc; ncode, out_data, nrg_waddr, nrg_wtime and exc_code <= 0.
  - No memory write.
- Decode fields: op=code[31:26], rt=code[20:16].
- Supported ops: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100, sw 101011, sh 101001, sb 101000.
- Any other op: out_data<=alu_res.
- Store forwarding: fwd = w_rg_wdata if w_rg_wtime==0 && w_rg_waddr==rt && rt!=0; otherwise st_data.
- Address: a=alu_res; idx=(a-ADDR_BASE)>>2.
- Fault when any of:
  - a<ADDR_BASE or idx>=DEPTH_WORDS;
  - word op with a[1:0]!=0;
  - halfword op with a[0]!=0.
- Load (no fault), one-cycle latency: out_data valid on the edge after issue.
  - Word: out_data=mem[idx].
  - Halfword: lane a[1], bits 16*a[1]+15 : 16*a[1]; lh sign-extends, lhu zero-extends.
  - Byte: lane a[1:0], bits 8*a[1:0]+7 : 8*a[1:0]; lb sign-extends, lbu zero-extends.
- Store (no fault): write on the same edge.
  - sw writes the full word.
  - sh writes the selected halfword lane with fwd[15:0].
  - sb writes the selected byte lane with fwd[7:0].
  - Other lanes are preserved.
- Load fault: exc_code<=1; out_data<=0; nrg_waddr<=0 to suppress the writeback.
- Store fault: exc_code<=2; memory unchanged.
- Non-memory ops: exc_code<=0.
- Pass-through: npc<=pc, ncode<=code, nrg_waddr<=rg_waddr (unless forced to 0), nrg_wtime <= (rg_wtime==0 ? 0 : rg_wtime-1). The time field saturates at 0.
- Back-to-back store then load to the same word: the load, issued the following cycle, returns the stored data.
- Stall asserted with a store present: no write occurs until the cycle stall deasserts.

Optional Feature:
- Macro: MEM_TRACE_EN.
- Defined: every committed store prints, via $display, time, pc, the word-aligned byte address and the full resulting word, in the form "@<pc>: *<addr> <= <word>".
- Defined: faulting, stalled and flushed stores print nothing.
- Not defined: no display statements are compiled; functional behaviour is identical.

Test Plan:
- Reset, then sw of 32'h1234_5678 to 0x10 followed by lw from 0x10: out_data=32'h1234_5678, exc_code=0, npc=pc of the lw.
- sb of 32'h0000_00AB to 0x13 over word 0, then lb and lbu from 0x13: lb gives 32'hFFFF_FFAB, lbu gives 32'h0000_00AB; lw from 0x10 gives 32'hAB00_0000.
- sw to rt=5 with st_data=1 while W has waddr=5, wtime=0, wdata=32'hDEAD_BEEF: memory holds DEADBEEF. Repeat with rt=0: memory holds st_data.
- lw from 0x11: exc_code=1, out_data=0, nrg_waddr=0. sw to DEPTH_WORDS*4: exc_code=2, memory unchanged.
- Stall held 3 cycles during an sw, then released: outputs constant and no write during the stall; the write lands on the release edge. Flush with an sw: no write, ncode=0.
- rg_wtime=2 followed by rg_wtime=0: nrg_wtime=1 then 0. Reset asserted mid-sequence: all outputs at reset values and memory zeroed on the next edge.

Source files
------------

// File: rtl/mem_stage_reg.sv
// MEM pipeline stage: word-organised data memory with little-endian byte/half/word
// loads and stores, W-stage store forwarding and address-fault reporting.
// Define MEM_TRACE_EN to print every committed store.
module mem_stage_reg #(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter logic [31:0] PC_RESET    = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] pc,
  input  logic [31:0] code,
  input  logic [31:0] alu_res,
  input  logic [31:0] st_data,
  input  logic [4:0]  rg_waddr,
  input  logic [31:0] rg_wtime,
  input  logic [4:0]  w_rg_waddr,
  input  logic [31:0] w_rg_wdata,
  input  logic [31:0] w_rg_wtime,
  output logic [31:0] npc,
  output logic [31:0] ncode,
  output logic [31:0] out_data,
  output logic [4:0]  nrg_waddr,
  output logic [31:0] nrg_wtime,
  output logic [1:0]  exc_code
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  logic [31:0] mem [DEPTH_WORDS];

  logic [5:0]  op;
  logic [4:0]  rt;
  size_e       sz;
  logic        is_load, is_store, sign_ext;
  logic [31:0] idx;
  logic [AW-1:0] widx;
  logic        range_bad, align_bad, fault;
  logic [31:0] fwd;
  logic [31:0] rd_word, wr_word, load_val;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic        mem_we;

  assign op = code[31:26];
  assign rt = code[20:16];

  always_comb begin
    sz       = SZ_NONE;
    is_load  = 1'b0;
    is_store = 1'b0;
    sign_ext = 1'b0;
    case (op)
      OP_LW:  begin sz = SZ_WORD; is_load = 1'b1; end
      OP_LH:  begin sz = SZ_HALF; is_load = 1'b1; sign_ext = 1'b1; end
      OP_LHU: begin sz = SZ_HALF; is_load = 1'b1; end
      OP_LB:  begin sz = SZ_BYTE; is_load = 1'b1; sign_ext = 1'b1; end
      OP_LBU: begin sz = SZ_BYTE; is_load = 1'b1; end
      OP_SW:  begin sz = SZ_WORD; is_store = 1'b1; end
      OP_SH:  begin sz = SZ_HALF; is_store = 1'b1; end
      OP_SB:  begin sz = SZ_BYTE; is_store = 1'b1; end
      default: ;
    endcase
  end

  // The below-base check covers the wrap of the subtraction.
  assign idx       = (alu_res - ADDR_BASE) >> 2;
  assign widx      = idx[AW-1:0];
  assign range_bad = (alu_res < ADDR_BASE) || (idx >= DEPTH32);
  assign align_bad = ((sz == SZ_WORD) && (alu_res[1:0] != 2'b00)) ||
                     ((sz == SZ_HALF) && alu_res[0]);
  assign fault     = (is_load || is_store) && (range_bad || align_bad);

  assign fwd = ((w_rg_wtime == 32'd0) && (w_rg_waddr == rt) && (rt != 5'd0)) ?
               w_rg_wdata : st_data;

  assign rd_word = range_bad ? 32'd0 : mem[widx];

  always_comb begin
    half_sel = alu_res[1] ? rd_word[31:16] : rd_word[15:0];
    byte_sel = rd_word[7:0];
    case (alu_res[1:0])
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      2'd3:    byte_sel = rd_word[31:24];
      default: byte_sel = rd_word[7:0];
    endcase
    case (sz)
      SZ_WORD: load_val = rd_word;
      SZ_HALF: load_val = {{16{sign_ext & half_sel[15]}}, half_sel};
      SZ_BYTE: load_val = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      default: load_val = alu_res;
    endcase
  end

  // Read-modify-write merge: untouched lanes keep the current word.
  always_comb begin
    wr_word = rd_word;
    case (sz)
      SZ_WORD: wr_word = fwd;
      SZ_HALF: begin
        if (alu_res[1]) wr_word[31:16] = fwd[15:0];
        else            wr_word[15:0]  = fwd[15:0];
      end
      SZ_BYTE: begin
        case (alu_res[1:0])
          2'd0: wr_word[7:0]   = fwd[7:0];
          2'd1: wr_word[15:8]  = fwd[7:0];
          2'd2: wr_word[23:16] = fwd[7:0];
          2'd3: wr_word[31:24] = fwd[7:0];
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign mem_we = !reset && !stall && !flush && is_store && !fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else if (mem_we) begin
      mem[widx] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      npc       <= PC_RESET;
      ncode     <= 32'd0;
      out_data  <= 32'd0;
      nrg_waddr <= 5'd0;
      nrg_wtime <= 32'd0;
      exc_code  <= 2'd0;
    end else if (stall) begin
      npc       <= npc;
    end else if (flush) begin
      npc       <= pc;
      ncode     <= 32'd0;
      out_data  <= 32'd0;
      nrg_waddr <= 5'd0;
      nrg_wtime <= 32'd0;
      exc_code  <= 2'd0;
    end else begin
      npc       <= pc;
      ncode     <= code;
      nrg_wtime <= (rg_wtime == 32'd0) ? 32'd0 : rg_wtime - 32'd1;
      if (is_load && fault) begin
        out_data  <= 32'd0;
        nrg_waddr <= 5'd0;
        exc_code  <= 2'd1;
      end else begin
        out_data  <= load_val;
        nrg_waddr <= rg_waddr;
        exc_code  <= (is_store && fault) ? 2'd2 : 2'd0;
      end
    end
  end

`ifdef MEM_TRACE_EN
  always_ff @(posedge clk) begin
    if (mem_we)
      $display("%0t @%h: *%h <= %h", $time, pc, {alu_res[31:2], 2'b00}, wr_word);
  end
`endif

endmodule
